rf_writeback_ctrl: RTL

// Owns the single register-file write port. Merges WB-stage results with correction write-backs

---
 rtl/rf_writeback_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: owns the single register-file write port, merging WB-stage
// results with correction (scrub) write-backs queued by the OP stage.
// Optional feature macro: RF_ECC_EN -- registers SEC-DED (39,32) Hsiao check
// bits alongside s_rf_val_o; when undefined s_rf_ecc_o is tied to zero.
module rf_writeback_ctrl #(
  parameter int unsigned FIX_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_mawb_we_i,
  input  logic [4:0]  s_mawb_rd_i,
  input  logic [31:0] s_mawb_val_i,
  input  logic        s_fix_req_i,
  input  logic [4:0]  s_fix_add_i,
  input  logic [31:0] s_fix_val_i,
  output logic        s_rf_we_o,
  output logic [4:0]  s_rf_add_o,
  output logic [31:0] s_rf_val_o,
  output logic [6:0]  s_rf_ecc_o,
  output logic        s_fixed_o,
  output logic        s_stall_o,
  output logic        s_fix_ovf_o
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(FIX_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t              state_q;
  logic [SW-1:0]       starve_q;
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       buf_add_q [FIX_DEPTH];
  logic [DW-1:0]       buf_val_q [FIX_DEPTH];
  logic [FIX_DEPTH-1:0] buf_live_q;

  logic                wb_wr, fix_ok, has_head, head_wr, blocked, pop;
  logic                direct, dup, room, push, ovf_n;
  logic [CW-1:0]       cnt_pop, cnt_n;
  logic [FIX_DEPTH-1:0] live_s, live_n;
  logic [DW-1:0]       mval [FIX_DEPTH];
  logic [AW-1:0]       add_n [FIX_DEPTH];
  logic [DW-1:0]       val_n [FIX_DEPTH];
  logic                rf_we_n, fixed_n;
  logic [AW-1:0]       rf_add_n;
  logic [DW-1:0]       rf_val_n;

  // Port arbitration and next contents of the pending-fix FIFO (head at index 0).
  always_comb begin
    wb_wr    = s_mawb_we_i && (s_mawb_rd_i != '0);
    fix_ok   = s_fix_req_i && (s_fix_add_i != '0) &&
               !(wb_wr && (s_mawb_rd_i == s_fix_add_i));
    has_head = (cnt_q != '0);
    for (int i = 0; i < FIX_DEPTH; i++)
      live_s[i] = buf_live_q[i] && !(wb_wr && (buf_add_q[i] == s_mawb_rd_i));
    head_wr  = has_head && live_s[0] && !wb_wr;
    blocked  = has_head && live_s[0] && wb_wr;
    // A superseded head leaves silently even while WB owns the port.
    pop      = has_head && !blocked;
    cnt_pop  = cnt_q - CW'(pop);
    // Empty queue and idle port: the fix goes straight to the RF.
    direct   = fix_ok && !wb_wr && !head_wr && (cnt_pop == '0);

    dup = 1'b0;
    for (int i = 0; i < FIX_DEPTH; i++) begin
      mval[i] = buf_val_q[i];
      if (fix_ok && live_s[i] && !((i == 0) && pop) && (buf_add_q[i] == s_fix_add_i)) begin
        dup     = 1'b1;
        mval[i] = s_fix_val_i;
      end
    end
    room  = (cnt_pop < CW'(FIX_DEPTH));
    push  = fix_ok && !dup && !direct && room;
    ovf_n = fix_ok && !dup && !direct && !room;

    for (int i = 0; i < FIX_DEPTH; i++) begin
      add_n[i] = buf_add_q[i];
      val_n[i] = mval[i];
    end
    live_n = live_s;
    if (pop) begin
      for (int i = 0; i < FIX_DEPTH - 1; i++) begin
        add_n[i]  = buf_add_q[i+1];
        val_n[i]  = mval[i+1];
        live_n[i] = live_s[i+1];
      end
      live_n[FIX_DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < FIX_DEPTH; i++) begin
      if (push && (CW'(i) == cnt_pop)) begin
        add_n[i]  = s_fix_add_i;
        val_n[i]  = s_fix_val_i;
        live_n[i] = 1'b1;
      end
    end
    cnt_n = cnt_pop + CW'(push);

    rf_we_n  = wb_wr || head_wr || direct;
    fixed_n  = head_wr || direct;
    rf_add_n = '0;
    rf_val_n = '0;
    if (wb_wr) begin
      rf_add_n = s_mawb_rd_i;
      rf_val_n = s_mawb_val_i;
    end else if (head_wr) begin
      rf_add_n = buf_add_q[0];
      rf_val_n = buf_val_q[0];
    end else if (direct) begin
      rf_add_n = s_fix_add_i;
      rf_val_n = s_fix_val_i;
    end
  end

  // Registered write port, FIFO storage and starvation FSM.
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      cnt_q       <= '0;
      buf_live_q  <= '0;
      for (int i = 0; i < FIX_DEPTH; i++) begin
        buf_add_q[i] <= '0;
        buf_val_q[i] <= '0;
      end
      s_rf_we_o   <= 1'b0;
      s_rf_add_o  <= '0;
      s_rf_val_o  <= '0;
      s_fixed_o   <= 1'b0;
      s_stall_o   <= 1'b0;
      s_fix_ovf_o <= 1'b0;
    end else begin
      cnt_q      <= cnt_n;
      buf_live_q <= live_n;
      for (int i = 0; i < FIX_DEPTH; i++) begin
        buf_add_q[i] <= add_n[i];
        buf_val_q[i] <= val_n[i];
      end
      s_rf_we_o   <= rf_we_n;
      s_rf_add_o  <= rf_add_n;
      s_rf_val_o  <= rf_val_n;
      s_fixed_o   <= fixed_n;
      s_fix_ovf_o <= ovf_n;
      case (state_q)
        IDLE: begin
          starve_q  <= '0;
          s_stall_o <= 1'b0;
          if (push) state_q <= PEND;
        end
        PEND: begin
          if (pop) begin
            starve_q  <= '0;
            s_stall_o <= 1'b0;
            if (cnt_n == '0) state_q <= IDLE;
          end else if (blocked) begin
            starve_q <= starve_q + SW'(1);
            if (starve_q == SW'(STARVE_MAX - 1)) begin
              state_q   <= FORCE;
              s_stall_o <= 1'b1;
            end
          end
        end
        FORCE: begin
          if (pop) begin
            starve_q  <= '0;
            s_stall_o <= 1'b0;
            state_q   <= (cnt_n != '0) ? PEND : IDLE;
          end else begin
            s_stall_o <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          starve_q  <= '0;
          s_stall_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_ECC_EN
  // Hsiao H-matrix columns: the 32 smallest weight-3 7-bit codes, one per data bit.
  localparam logic [6:0] HCOL [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  logic [6:0] ecc_n, ecc_q;

  // Check bits of the value about to be registered on s_rf_val_o.
  always_comb begin
    ecc_n = '0;
    for (int i = 0; i < 32; i++)
      if (rf_val_n[i]) ecc_n = ecc_n ^ HCOL[i];
  end

  // Check bits registered in the same cycle as the data.
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) ecc_q <= '0;
    else         ecc_q <= ecc_n;
  end

  assign s_rf_ecc_o = ecc_q;
`else
  assign s_rf_ecc_o = 7'b0;
`endif

endmodule
